phase_sequencer: RTL

//  Synchronous replacement for the ripple divide-by-8: one clock domain, with a clock-enable tick instead of derived clocks.

---
 rtl/phase_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// Phase sequencer: single-clock divider that produces a clock-enable tick and
// walks the processor through FETCH/DECODE/EXECUTE/WRITEBACK. It supports
// stall and single-step debug.
//
// The sequencer has no valid/ready handshake. Downstream registers run on clk
// and capture only in a cycle where their phase_en bit is high. phase_en is a
// one-cycle qualifier and never a held level.
//
// The phase output is the FSM state register, exposed directly for debug.
module phase_sequencer #(
  parameter int DIV_W       = 4,
  parameter int DEFAULT_DIV = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic             stall,
  input  logic             step_mode,
  input  logic             step_req,
  output logic             tick,
  output logic [1:0]       phase,
  output logic [3:0]       phase_en,
  output logic             cycle_done,
  output logic [DIV_W-1:0] div_ratio
);

  // Ratios 0 and 1 both mean "tick every cycle".
  localparam logic [DIV_W-1:0] RESET_RATIO =
    (DEFAULT_DIV < 2) ? DIV_W'(1) : DIV_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    PH_FETCH     = 2'd0,
    PH_DECODE    = 2'd1,
    PH_EXECUTE   = 2'd2,
    PH_WRITEBACK = 2'd3
  } phase_t;

  logic [DIV_W-1:0] ratio_q;
  logic [DIV_W-1:0] cnt_q;
  logic             tick_q;
  logic [DIV_W-1:0] load_ratio;
  logic [DIV_W-1:0] ratio_last;

  logic             token_q;
  logic             step_req_q;
  logic             step_rise;
  logic             go;
  logic             advance;

  phase_t           state_q;
  phase_t           state_d;

  assign load_ratio = (div_value == '0) ? DIV_W'(1) : div_value;
  assign ratio_last = ratio_q - DIV_W'(1);

  // The phase may move only when it is neither stalled nor waiting for a step token.
  assign go        = ~stall & (~step_mode | token_q);
  assign advance   = tick_q & go;
  assign step_rise = step_req & ~step_req_q;

  // Divider: a load restarts the count from the load edge and wins over a wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      ratio_q <= RESET_RATIO;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else if (div_load) begin
      ratio_q <= load_ratio;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else if (cnt_q == ratio_last) begin
      cnt_q   <= '0;
      tick_q  <= 1'b1;
    end else begin
      cnt_q   <= cnt_q + DIV_W'(1);
      tick_q  <= 1'b0;
    end
  end

  // Step token: a rising request arms the token. A step-mode advance consumes it.
  // A new request on the consuming edge wins, so that request is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      token_q    <= 1'b0;
      step_req_q <= 1'b0;
    end else begin
      step_req_q <= step_req;
      if (step_rise) begin
        token_q <= 1'b1;
      end else if (advance & step_mode) begin
        token_q <= 1'b0;
      end
    end
  end

  // Phase state register. Reset abandons any partial instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PH_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next phase and one-hot enable. Both are active only on an advancing tick.
  always_comb begin
    state_d  = state_q;
    phase_en = 4'b0000;
    if (advance) begin
      case (state_q)
        PH_FETCH: begin
          phase_en = 4'b0001;
          state_d  = PH_DECODE;
        end
        PH_DECODE: begin
          phase_en = 4'b0010;
          state_d  = PH_EXECUTE;
        end
        PH_EXECUTE: begin
          phase_en = 4'b0100;
          state_d  = PH_WRITEBACK;
        end
        default: begin
          phase_en = 4'b1000;
          state_d  = PH_FETCH;
        end
      endcase
    end
  end

  assign tick       = tick_q;
  assign phase      = state_q;
  assign cycle_done = phase_en[3];
  assign div_ratio  = ratio_q;

endmodule
